dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory arbiter that shares the pipeline CPU's data memory between the MEM stage and a board-level debug port (switch/seven-segment readback and a test loader). The CPU has priority. A starvation counter guarantees the debug port a slot under sustained CPU traffic. Any CPU request that is not granted stalls the pipeline. Sits in `board_top` between `u_cpu`'s MEM stage, the debug logic and the data memory array.

## Interface
- `ADDR_W`, default 10: word address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 8: number of consecutive CPU grants that may occur while debug waits; must be ≥1.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  MEM stage requests an access this cycle.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_W  word address.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_stall`  out  1  request present but not granted; freezes the pipeline.
- `cpu_rdata`  out  DATA_W  load data, valid with `cpu_rvalid`.
- `cpu_rvalid`  out  1  load data returned, one cycle after the grant.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/ADDR_W/DATA_W  debug request, same meaning as the CPU fields.
- `dbg_gnt`  out  1  debug access accepted this cycle.
- `dbg_rdata`  out  DATA_W  debug read data.
- `dbg_rvalid`  out  1  debug read data valid.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`  out  1/1/ADDR_W/DATA_W  memory port; the memory samples these on the clock edge.
- `mem_rdata`  in  DATA_W  synchronous read data, valid the cycle after `mem_en`.
- `starved`  out  1  `streak == STARVE_LIMIT` (drives a debug LED).

## Operation
- Grant decision is combinational from the current requests and the registered `streak` counter.
  - `cpu_req` only: CPU is granted.
  - `dbg_req` only: debug is granted.
  - Both requests, `streak < STARVE_LIMIT`: CPU is granted.
  - Both requests, `streak == STARVE_LIMIT`: debug is granted.
- Memory port muxing:
  - Memory port fields come from the granted requester.
  - `mem_en` = any grant.
  - With no grant, `mem_we` = 0 and the other port fields are don't-care.
- `cpu_stall` = `cpu_req & ~cpu_grant`.
- `dbg_gnt` = debug grant.
- Requesters hold request and payload stable until granted; the arbiter does not latch un-granted requests.
- `streak` (width clog2(STARVE_LIMIT+1)):
  - +1 when CPU is granted while `dbg_req` = 1, saturating at STARVE_LIMIT.
  - Cleared to 0 when debug is granted or `dbg_req` = 0.
- Read-return tag `rd_owner` ∈ {NONE, CPU, DBG}, registered each cycle:
  - CPU if a CPU load was granted.
  - DBG if a debug load was granted.
  - NONE otherwise, including every write.
- Return outputs:
  - `cpu_rvalid` = (`rd_owner` == CPU); `dbg_rvalid` = (`rd_owner` == DBG).
  - Both `*_rdata` = `mem_rdata`, qualified only by their own rvalid.
- Writes produce no rvalid.
- Read-after-write to the same address in consecutive grants returns the new data; the memory is write-first.

## Timing
- Reset: while `reset` = 1, all outputs are 0: `mem_en`, `mem_we`, `cpu_stall`, `dbg_gnt`, both rvalids and `starved`. Grants are forced off.
- On reset the registers clear: `streak` = 0, `rd_owner` = NONE.
- Reset arriving while a read is outstanding drops it: no rvalid on the cycle after reset.
- Grant latency is 0 cycles; an uncontended request is granted in the cycle it is raised.
- Read latency: rvalid is asserted exactly 1 cycle after the granted load. Loads can be issued every cycle, with no bubble.
- Worst-case debug wait under continuous CPU traffic is STARVE_LIMIT cycles; it is granted on cycle STARVE_LIMIT+1. CPU stalls exactly 1 cycle at that point.
- After a debug grant, `streak` is back at 0, so CPU wins the next contention.
- The rvalid for a load and a new grant can be asserted in the same cycle; they are independent.

## Test plan
- Reset, then CPU store `addr` 0 = 5, CPU load `addr` 0 → `mem_we` pulse on the store cycle, `cpu_rvalid` = 1 and `cpu_rdata` = 5 the cycle after the load, `cpu_stall` = 0 throughout.
- Debug only: load `addr` 3, preloaded with 0xDEADBEEF → `dbg_gnt` on cycle 0, `dbg_rvalid` with 0xDEADBEEF on cycle 1, `cpu_rvalid` stays 0.
- Simultaneous single requests, CPU store `addr` 1 = 7 and debug load `addr` 1 → CPU granted first with `dbg_gnt` = 0. Next cycle debug is granted and reads 7.
- Starvation, `STARVE_LIMIT` = 8: `cpu_req` held for 20 cycles, `dbg_req` held → 8 CPU grants, `starved` = 1. Cycle 9 has `dbg_gnt` = 1 and `cpu_stall` = 1. CPU resumes on cycle 10 with `streak` = 0.
- Reset mid-operation: CPU load granted, `reset` = 1 on the next edge → `cpu_rvalid` stays 0. After release, `streak` = 0 and `rd_owner` = NONE.
- Back-to-back mixed loads CPU/DBG/CPU on addresses 0, 1, 2 holding 10, 11, 12, with requests non-overlapping → rvalids alternate owner on consecutive cycles, data 10, 11, 12 in order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and the board debug port.
// CPU has priority; a streak counter forces a debug slot after STARVE_LIMIT contended CPU grants.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starved
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] Limit = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} owner_e;

  logic [StreakW-1:0] streak_q, streak_d;
  owner_e             rd_owner_q, rd_owner_d;
  logic               cpu_grant, dbg_grant, at_limit;

  always_comb begin
    at_limit  = (streak_q == Limit);
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      if (cpu_req && !(dbg_req && at_limit)) begin
        cpu_grant = 1'b1;
      end else if (dbg_req) begin
        dbg_grant = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_grant | dbg_grant;
    mem_we    = cpu_grant ? cpu_we : (dbg_grant & dbg_we);
    mem_addr  = dbg_grant ? dbg_addr  : cpu_addr;
    mem_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
    cpu_stall = cpu_req & ~cpu_grant & ~reset;
    dbg_gnt   = dbg_grant;
  end

  always_comb begin
    streak_d = streak_q;
    if (dbg_grant || !dbg_req) begin
      streak_d = '0;
    end else if (cpu_grant && !at_limit) begin
      streak_d = streak_q + StreakW'(1);
    end

    rd_owner_d = OwnNone;
    if (cpu_grant && !cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (dbg_grant && !dbg_we) begin
      rd_owner_d = OwnDbg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      rd_owner_q <= OwnNone;
    end else begin
      streak_q   <= streak_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Outputs are gated during reset so a read outstanding at reset is dropped.
  always_comb begin
    cpu_rvalid = !reset && (rd_owner_q == OwnCpu);
    dbg_rvalid = !reset && (rd_owner_q == OwnDbg);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    starved    = !reset && at_limit;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus a hand-written starvation sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [9:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, starved;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W      (10),
    .DATA_W      (32),
    .STARVE_LIMIT(8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .starved   (starved)
  );

  // Write-first synchronous memory model.
  logic [31:0] mem_array [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_array[mem_addr] <= mem_wdata;
        mem_rdata           <= mem_wdata;
      end else begin
        mem_rdata <= mem_array[mem_addr];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [9:0]  caddr;
    logic [31:0] cwd;
    logic        dreq, dwe;
    logic [9:0]  daddr;
    logic [31:0] dwd;
    logic        stall, dgnt, men, mwe, crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
    logic        strv;
  } vec_t;

  localparam int NVec = 21;
  vec_t vecs [NVec];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic creq, input logic cwe, input logic [9:0] ca,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [9:0] da, input logic [31:0] dwd);
    @(negedge clk);
    reset     = rst;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cwd;
    dbg_req   = dreq;
    dbg_we    = dwe;
    dbg_addr  = da;
    dbg_wdata = dwd;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    {cpu_req, cpu_we, dbg_req, dbg_we} = '0;
    cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;

    //          rst creq cwe caddr cwd   dreq dwe daddr dwd            stall dgnt men mwe crv crd  drv drd           strv
    vecs[0]  = '{1, 1, 0, 0, 0,          1, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  0, 0,            0};
    vecs[1]  = '{1, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  0, 0,            0};
    vecs[2]  = '{0, 1, 1, 0, 5,          0, 0, 0, 0,                   0, 0, 1, 1, 0, 0,  0, 0,            0};
    vecs[3]  = '{0, 1, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 1, 0, 0, 0,  0, 0,            0};
    vecs[4]  = '{0, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 1, 5,  0, 0,            0};
    vecs[5]  = '{0, 0, 0, 0, 0,          1, 1, 3, 32'hDEADBEEF,        0, 1, 1, 1, 0, 0,  0, 0,            0};
    vecs[6]  = '{0, 0, 0, 0, 0,          1, 0, 3, 0,                   0, 1, 1, 0, 0, 0,  0, 0,            0};
    vecs[7]  = '{0, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 0};
    vecs[8]  = '{0, 1, 1, 1, 7,          1, 0, 1, 0,                   0, 0, 1, 1, 0, 0,  0, 0,            0};
    vecs[9]  = '{0, 0, 0, 0, 0,          1, 0, 1, 0,                   0, 1, 1, 0, 0, 0,  0, 0,            0};
    vecs[10] = '{0, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  1, 7,            0};
    vecs[11] = '{0, 1, 1, 0, 10,         0, 0, 0, 0,                   0, 0, 1, 1, 0, 0,  0, 0,            0};
    vecs[12] = '{0, 0, 0, 0, 0,          1, 1, 1, 11,                  0, 1, 1, 1, 0, 0,  0, 0,            0};
    vecs[13] = '{0, 1, 1, 2, 12,         0, 0, 0, 0,                   0, 0, 1, 1, 0, 0,  0, 0,            0};
    vecs[14] = '{0, 1, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 1, 0, 0, 0,  0, 0,            0};
    vecs[15] = '{0, 0, 0, 0, 0,          1, 0, 1, 0,                   0, 1, 1, 0, 1, 10, 0, 0,            0};
    vecs[16] = '{0, 1, 0, 2, 0,          0, 0, 0, 0,                   0, 0, 1, 0, 0, 0,  1, 11,           0};
    vecs[17] = '{0, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 1, 12, 0, 0,            0};
    vecs[18] = '{0, 1, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 1, 0, 0, 0,  0, 0,            0};
    vecs[19] = '{1, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  0, 0,            0};
    vecs[20] = '{0, 0, 0, 0, 0,          0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,  0, 0,            0};

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
      check("cpu_stall", i, 32'(cpu_stall), 32'(vecs[i].stall));
      check("dbg_gnt", i, 32'(dbg_gnt), 32'(vecs[i].dgnt));
      check("mem_en", i, 32'(mem_en), 32'(vecs[i].men));
      check("mem_we", i, 32'(mem_we), 32'(vecs[i].mwe));
      check("cpu_rvalid", i, 32'(cpu_rvalid), 32'(vecs[i].crv));
      check("cpu_rdata", i, cpu_rdata, vecs[i].crd);
      check("dbg_rvalid", i, 32'(dbg_rvalid), 32'(vecs[i].drv));
      check("dbg_rdata", i, dbg_rdata, vecs[i].drd);
      check("starved", i, 32'(starved), 32'(vecs[i].strv));
    end

    // Partial streak, then reset: the full count must restart from zero afterwards.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 1, 0, 1, 0);
      check("pre_dbg_gnt", 100 + k, 32'(dbg_gnt), 32'd0);
      check("pre_stall", 100 + k, 32'(cpu_stall), 32'd0);
    end
    drive(1, 1, 0, 0, 0, 1, 0, 1, 0);
    check("rst_dbg_gnt", 103, 32'(dbg_gnt), 32'd0);
    check("rst_mem_en", 103, 32'(mem_en), 32'd0);
    check("rst_cpu_rvalid", 103, 32'(cpu_rvalid), 32'd0);

    // Both requesters loading continuously: debug wins every 9th cycle.
    for (int k = 1; k <= 20; k++) begin
      bit dbg_slot, prev_dbg;
      dbg_slot = (k % 9 == 0);
      prev_dbg = (k > 1) && ((k - 1) % 9 == 0);
      drive(0, 1, 0, 0, 0, 1, 0, 1, 0);
      check("starve_dbg_gnt", 200 + k, 32'(dbg_gnt), 32'(dbg_slot));
      check("starve_cpu_stall", 200 + k, 32'(cpu_stall), 32'(dbg_slot));
      check("starve_starved", 200 + k, 32'(starved), 32'(dbg_slot));
      check("starve_mem_en", 200 + k, 32'(mem_en), 32'd1);
      check("starve_cpu_rvalid", 200 + k, 32'(cpu_rvalid), 32'((k > 1) && !prev_dbg));
      check("starve_cpu_rdata", 200 + k, cpu_rdata, ((k > 1) && !prev_dbg) ? 32'd10 : 32'd0);
      check("starve_dbg_rvalid", 200 + k, 32'(dbg_rvalid), 32'(prev_dbg));
      check("starve_dbg_rdata", 200 + k, dbg_rdata, prev_dbg ? 32'd11 : 32'd0);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tail_cpu_rvalid", 300, 32'(cpu_rvalid), 32'd1);
    check("tail_cpu_rdata", 300, cpu_rdata, 32'd10);
    check("tail_starved", 300, 32'(starved), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
